johnson_ring_counter_gen: RTL and testbench

- Parametrised, registered shift-register counter. Runtime-selectable mode: Johnson (twisted-ring, 2*WIDTH states) or one-hot ring (WIDTH states).
- Adds count enable, bidirectional shift, parallel load with legality check, and illegal-state self-recovery.
- Outputs a binary phase index and a wrap pulse.
- Used as a phase/sequence generator for multiphase timing and sequencer logic.

---
 rtl/johnson_ring_counter_gen.sv | 128 ++++++++++++
 tb/tb_johnson_ring_counter_gen.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/johnson_ring_counter_gen.sv
// Johnson / one-hot ring phase generator with load, bidirectional
// stepping, illegal-state recovery, binary phase index and wrap pulse.
module johnson_ring_counter_gen #(
    parameter int WIDTH = 4,
    localparam int PW = $clog2(2*WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] q,
    output logic [PW-1:0]    phase,
    output logic             wrap,
    output logic             err
);

    // {legal, index}: MSB-anchored run of L ones sits at phase L,
    // LSB-anchored run of L ones sits at phase 2*WIDTH-L.
    function automatic logic [PW:0] j_lookup(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] ones;
        logic [PW:0]      r;
        ones = '1;
        r    = '0;
        for (int l = 0; l <= WIDTH; l++) begin
            if (v == ~(ones >> l)) r = {1'b1, PW'(l)};
        end
        for (int l = 1; l < WIDTH; l++) begin
            if (v == (ones >> (WIDTH - l))) r = {1'b1, PW'(2*WIDTH - l)};
        end
        return r;
    endfunction

    function automatic logic [PW:0] r_lookup(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] b;
        logic [PW:0]      r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            b    = '0;
            b[i] = 1'b1;
            if (v == b) r = {1'b1, PW'((WIDTH - i) % WIDTH)};
        end
        return r;
    endfunction

    function automatic logic [PW:0] lookup(input logic m,
                                           input logic [WIDTH-1:0] v);
        return m ? r_lookup(v) : j_lookup(v);
    endfunction

    function automatic logic [WIDTH-1:0] seed(input logic m);
        return m ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
    endfunction

    logic             mode_q;
    logic [PW:0]      cur;
    logic [PW:0]      ldl;
    logic [PW:0]      per;
    logic [PW:0]      pm1;
    logic             fb_r;
    logic             fb_l;
    logic [WIDTH-1:0] adv;
    logic [PW-1:0]    nph;
    logic [WIDTH-1:0] q_d;
    logic [PW-1:0]    ph_d;
    logic             wrap_d;
    logic             err_d;

    always_comb begin
        cur  = lookup(mode_q, q);
        ldl  = lookup(mode_q, ld_val);
        per  = mode_q ? (PW+1)'(WIDTH) : (PW+1)'(2*WIDTH);
        pm1  = per - 1'b1;
        // Johnson inverts the feedback bit, ring passes it through.
        fb_r = q[0] ^ ~mode_q;
        fb_l = q[WIDTH-1] ^ ~mode_q;
        adv  = dir ? {q[WIDTH-2:0], fb_l} : {fb_r, q[WIDTH-1:1]};
        if (dir)
            nph = (phase == '0) ? pm1[PW-1:0] : phase - 1'b1;
        else
            nph = ({1'b0, phase} == pm1) ? '0 : phase + 1'b1;

        q_d    = q;
        ph_d   = phase;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        priority case (1'b1)
            (mode != mode_q): begin
                q_d  = seed(mode);
                ph_d = '0;
            end
            (!cur[PW]): begin
                q_d   = seed(mode_q);
                ph_d  = '0;
                err_d = 1'b1;
            end
            (ld && ldl[PW]): begin
                q_d  = ld_val;
                ph_d = ldl[PW-1:0];
            end
            ld: err_d = 1'b1;
            en: begin
                q_d    = adv;
                ph_d   = nph;
                wrap_d = (nph == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        mode_q <= mode;
        if (!rst) begin
            q     <= seed(mode);
            phase <= '0;
            wrap  <= 1'b0;
            err   <= 1'b0;
        end else begin
            q     <= q_d;
            phase <= ph_d;
            wrap  <= wrap_d;
            err   <= err_d;
        end
    end

endmodule

// File: tb/tb_johnson_ring_counter_gen.sv
// Bench for johnson_ring_counter_gen: directed walk-through followed by
// randomized traffic against a phase-indexed reference model.
module tb_johnson_ring_counter_gen;

    localparam int W  = 4;
    localparam int PW = $clog2(2*W);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          dir = 1'b0;
    logic          mode = 1'b0;
    logic          ld = 1'b0;
    logic [W-1:0]  ld_val = '0;
    logic [W-1:0]  q;
    logic [PW-1:0] phase;
    logic          wrap;
    logic          err;

    int vectors = 0;
    int miscompares = 0;

    bit m_mode = 1'b0;
    int m_ph = 0;
    bit m_wrap = 1'b0;
    bit m_err = 1'b0;

    always #5 clk = ~clk;

    johnson_ring_counter_gen #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode),
        .ld(ld), .ld_val(ld_val), .q(q), .phase(phase),
        .wrap(wrap), .err(err)
    );

    function automatic int per(bit m);
        return m ? W : 2*W;
    endfunction

    // Pattern shown at phase p, built from the sequence definition.
    function automatic logic [W-1:0] pat(bit m, int p);
        logic [W-1:0] r;
        r = '0;
        if (m) begin
            r[(W - p) % W] = 1'b1;
        end else if (p <= W) begin
            for (int i = 0; i < p; i++) r[W-1-i] = 1'b1;
        end else begin
            for (int i = 0; i < 2*W - p; i++) r[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic int idx(bit m, logic [W-1:0] v);
        for (int p = 0; p < per(m); p++)
            if (pat(m, p) == v) return p;
        return -1;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit e, input bit d, input bit m,
                        input bit l, input logic [W-1:0] lv,
                        input bit frc, input logic [W-1:0] fv);
        int k;
        @(negedge clk);
        rst = r; en = e; dir = d; mode = m; ld = l; ld_val = lv;
        if (frc) begin
            force dut.q = fv;
            #1;
            release dut.q;
        end
        @(posedge clk);
        m_wrap = 1'b0;
        m_err  = 1'b0;
        if (!r) begin
            m_mode = m;
            m_ph   = 0;
        end else if (m != m_mode) begin
            m_mode = m;
            m_ph   = 0;
        end else if (idx(m_mode, frc ? fv : pat(m_mode, m_ph)) < 0) begin
            m_ph  = 0;
            m_err = 1'b1;
        end else if (l) begin
            k = idx(m_mode, lv);
            if (k >= 0) m_ph = k;
            else m_err = 1'b1;
        end else if (e) begin
            m_ph = d ? (m_ph + per(m_mode) - 1) % per(m_mode)
                     : (m_ph + 1) % per(m_mode);
            m_wrap = (m_ph == 0);
        end
        #1;
        chk("q", 32'(q), 32'(pat(m_mode, m_ph)));
        chk("phase", 32'(phase), 32'(m_ph));
        chk("wrap", 32'(wrap), 32'(m_wrap));
        chk("err", 32'(err), 32'(m_err));
    endtask

    task automatic go(bit e, bit d, bit m);
        step(1'b1, e, d, m, 1'b0, '0, 1'b0, '0);
    endtask

    logic [W-1:0] seq1 [9];
    bit           rr, mm, ll;
    logic [W-1:0] lv;

    initial begin
        seq1 = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111,
                 4'b0011, 4'b0001, 4'b0000, 4'b1000};

        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        chk("rst_q", 32'(q), 32'h0);
        for (int i = 0; i < 9; i++) begin
            go(1'b1, 1'b0, 1'b0);
            chk("seq_q", 32'(q), 32'(seq1[i]));
        end
        chk("seq_wrapclr", 32'(wrap), 32'h0);

        go(1'b1, 1'b0, 1'b0);
        chk("j_q1100", 32'(q), 32'hC);
        go(1'b1, 1'b1, 1'b0);
        go(1'b1, 1'b1, 1'b0);
        chk("left_wrap", 32'(wrap), 32'h1);
        go(1'b1, 1'b1, 1'b0);
        chk("left_under_q", 32'(q), 32'h1);
        chk("left_under_ph", 32'(phase), 32'h7);

        for (int i = 0; i < 4; i++) go(1'b1, 1'b0, 1'b0);
        chk("pre_mode_q", 32'(q), 32'hE);
        go(1'b1, 1'b0, 1'b1);
        chk("mode_sw_q", 32'(q), 32'h1);
        for (int i = 0; i < 4; i++) go(1'b1, 1'b0, 1'b1);
        chk("ring_wrap", 32'(wrap), 32'h1);

        go(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0110, 1'b0, '0);
        chk("ld_bad_err", 32'(err), 32'h1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0011, 1'b0, '0);
        chk("ld_ok_ph", 32'(phase), 32'h6);

        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 4'b1010);
        chk("upset_err", 32'(err), 32'h1);
        go(1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 5; i++) go(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) go(1'b0, 1'b0, 1'b0);
        chk("idle_q", 32'(q), 32'h7);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        go(1'b1, 1'b0, 1'b0);
        chk("post_rst_q", 32'(q), 32'h8);

        for (int n = 0; n < 600; n++) begin
            rr = ($urandom_range(0, 29) != 0);
            mm = ($urandom_range(0, 11) == 0) ? ~mode : mode;
            ll = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 1) != 0)
                lv = W'($urandom);
            else
                lv = pat(m_mode, $urandom_range(0, per(m_mode) - 1));
            step(rr, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 mm, ll, lv, 1'b0, '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
